// File: rtl/memory_writeback.sv
// MEM/WB pipeline stage: performs lw/sw over a req/ack data-memory port and
// stalls upstream until the access completes, flagging misaligned or timed-out accesses.
module memory_writeback #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        XM_valid,
  input  logic        XM_MemtoReg,
  input  logic        XM_RegWrite,
  input  logic        XM_MemRead,
  input  logic        XM_MemWrite,
  input  logic [4:0]  XM_RD,
  input  logic [31:0] XM_ALUout,
  input  logic [31:0] XM_MD,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        stall,
  output logic        mem_err,
  output logic        MW_MemtoReg,
  output logic        MW_RegWrite,
  output logic [4:0]  MW_RD,
  output logic [31:0] MDR,
  output logic [31:0] MW_ALUout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  state_t          r_state, w_next;
  logic [TO_W-1:0] r_cnt;
  logic            w_memop, w_misal, w_timeout;

  assign w_memop   = XM_valid & (XM_MemRead | XM_MemWrite);
  assign w_misal   = w_memop & (XM_ALUout[1:0] != 2'b00);
  assign w_timeout = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Stall is forced low while reset is asserted so upstream never sees a
  // stall from an instruction that the reset has just discarded.
  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    case (r_state)
      IDLE: if (w_memop && !w_misal) begin
        w_next = BUSY;
        stall  = rst;
      end
      BUSY: if (dm_ack || w_timeout) w_next = IDLE;
            else                     stall  = rst;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      mem_err     <= 1'b0;
      MW_MemtoReg <= 1'b0;
      MW_RegWrite <= 1'b0;
      MW_RD       <= '0;
      MDR         <= '0;
      MW_ALUout   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_memop) begin
            MW_MemtoReg <= XM_MemtoReg;
            MW_RD       <= XM_RD;
            MW_ALUout   <= XM_ALUout;
            MW_RegWrite <= XM_valid & XM_RegWrite;
          end else if (w_misal) begin
            mem_err     <= 1'b1;
            MW_RegWrite <= 1'b0;
          end else begin
            dm_req      <= 1'b1;
            dm_we       <= XM_MemWrite;
            dm_addr     <= XM_ALUout;
            dm_wdata    <= XM_MD;
            r_cnt       <= '0;
            MW_RegWrite <= 1'b0;
          end
        end
        BUSY: begin
          r_cnt       <= r_cnt + TO_W'(1);
          MW_RegWrite <= 1'b0;
          // An ack arriving on the final timeout cycle still completes the access.
          if (dm_ack) begin
            dm_req      <= 1'b0;
            if (XM_MemRead) MDR <= dm_rdata;
            MW_MemtoReg <= XM_MemtoReg;
            MW_RD       <= XM_RD;
            MW_ALUout   <= XM_ALUout;
            MW_RegWrite <= XM_RegWrite & XM_MemRead;
          end else if (w_timeout) begin
            dm_req  <= 1'b0;
            mem_err <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
